// File: rtl/keypad_scanner_if.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scanner_if
// Description : Keypad matrix lines plus the key-event outputs towards the
//               display controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface keypad_scanner_if;
    logic [3:0] Rows;
    logic [3:0] Columns;
    logic [3:0] KeyCode;
    logic       KeyValid;
    logic       Found;
    logic       Locked;

    // master: the scanner itself; slave: keypad lines and the downstream consumer
    modport master (
        input  Rows,
        output Columns,
        output KeyCode,
        output KeyValid,
        output Found,
        output Locked
    );

    modport slave (
        output Rows,
        input  Columns,
        input  KeyCode,
        input  KeyValid,
        input  Found,
        input  Locked
    );
endinterface
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scanner
// Description : 4x4 matrix keypad scanner with tick-based debounce and
//               column hold until the pressed key is released.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner #(
    parameter int Divider       = 50000,
    parameter int DebounceTicks = 4
) (
    input  wire logic        ClockIn,
    input  wire logic        Reset,
    keypad_scanner_if.master kp
);

    localparam int c_TickWidth = (Divider > 1) ? $clog2(Divider) : 1;
    localparam int c_DebWidth  = $clog2(DebounceTicks + 1);

    localparam logic [c_TickWidth-1:0] c_TickLast  = c_TickWidth'(Divider - 1);
    localparam logic [c_DebWidth-1:0]  c_DebTarget = c_DebWidth'(DebounceTicks);
    localparam logic [3:0]             c_NoKey     = 4'b1111;

    generate
        if (Divider < 2 || DebounceTicks < 1) begin : g_badParams
            $error("keypad_scanner: Divider must be >= 2 and DebounceTicks >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_LOCKED   = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    state_t                 r_state;
    logic [3:0]             r_rowsMeta;
    logic [3:0]             r_rowsS;
    logic [c_TickWidth-1:0] r_tickCount;
    logic [c_DebWidth-1:0]  r_debCount;
    logic [3:0]             r_ref;
    logic [1:0]             r_col;
    logic [3:0]             r_columns;
    logic [3:0]             r_keyCode;
    logic                   r_keyValid;
    logic                   r_found;
    logic                   r_locked;

    logic                   w_tick;
    logic                   w_onePress;
    logic [1:0]             w_rowIdx;
    logic [1:0]             w_colNext;
    logic [c_DebWidth-1:0]  w_debNext;

    // Rows is asynchronous to ClockIn; idle level is all-high
    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            r_rowsMeta <= c_NoKey;
            r_rowsS    <= c_NoKey;
        end else begin
            r_rowsMeta <= kp.Rows;
            r_rowsS    <= r_rowsMeta;
        end
    end

    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            r_tickCount <= '0;
        end else if (r_tickCount == c_TickLast) begin
            r_tickCount <= '0;
        end else begin
            r_tickCount <= r_tickCount + c_TickWidth'(1);
        end
    end

    assign w_tick    = (r_tickCount == c_TickLast);
    assign w_colNext = r_col + 2'd1;
    assign w_debNext = r_debCount + c_DebWidth'(1);

    // Exactly one low row is a press; anything else (ghosting, idle) is not
    always_comb begin
        w_onePress = 1'b0;
        w_rowIdx   = 2'd0;
        case (r_rowsS)
            4'b1110: begin w_onePress = 1'b1; w_rowIdx = 2'd0; end
            4'b1101: begin w_onePress = 1'b1; w_rowIdx = 2'd1; end
            4'b1011: begin w_onePress = 1'b1; w_rowIdx = 2'd2; end
            4'b0111: begin w_onePress = 1'b1; w_rowIdx = 2'd3; end
            default: begin w_onePress = 1'b0; w_rowIdx = 2'd0; end
        endcase
    end

    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            r_state    <= ST_SCAN;
            r_col      <= 2'd0;
            r_columns  <= 4'b1110;
            r_keyCode  <= 4'd0;
            r_keyValid <= 1'b0;
            r_found    <= 1'b0;
            r_locked   <= 1'b0;
            r_debCount <= '0;
            r_ref      <= c_NoKey;
        end else begin
            r_keyValid <= 1'b0;
            if (w_tick) begin
                case (r_state)
                    ST_SCAN: begin
                        if (w_onePress) begin
                            r_ref      <= r_rowsS;
                            r_debCount <= '0;
                            r_state    <= ST_DEBOUNCE;
                        end else begin
                            r_col     <= w_colNext;
                            r_columns <= ~(4'b0001 << w_colNext);
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (r_rowsS == r_ref) begin
                            if (w_debNext == c_DebTarget) begin
                                // code = 4*row + column, i.e. {row, column}
                                r_keyCode  <= {w_rowIdx, r_col};
                                r_keyValid <= 1'b1;
                                r_found    <= 1'b1;
                                r_locked   <= 1'b1;
                                r_debCount <= '0;
                                r_state    <= ST_LOCKED;
                            end else begin
                                r_debCount <= w_debNext;
                            end
                        end else begin
                            r_locked <= 1'b0;
                            r_state  <= ST_SCAN;
                        end
                    end
                    ST_LOCKED: begin
                        if (r_rowsS == c_NoKey) begin
                            r_debCount <= '0;
                            r_state    <= ST_RELEASE;
                        end
                    end
                    ST_RELEASE: begin
                        if (r_rowsS == c_NoKey) begin
                            if (w_debNext == c_DebTarget) begin
                                r_locked   <= 1'b0;
                                r_debCount <= '0;
                                r_state    <= ST_SCAN;
                            end else begin
                                r_debCount <= w_debNext;
                            end
                        end else begin
                            // a bounce during release re-locks without a new key event
                            r_state <= ST_LOCKED;
                        end
                    end
                    default: begin
                        r_state <= ST_SCAN;
                    end
                endcase
            end
        end
    end

    assign kp.Columns  = r_columns;
    assign kp.KeyCode  = r_keyCode;
    assign kp.KeyValid = r_keyValid;
    assign kp.Found    = r_found;
    assign kp.Locked   = r_locked;

endmodule
`default_nettype wire
